ocm_channel_writer: RTL
=======================

Name: ocm_channel_writer

Overview:
- Collects NUM_PIX output vectors from the CNN pipeline; each vector holds NUM_CH channels of DATA_W bits.
- Writes them into an on-chip RAM slave port in channel-major order, one word per cycle.
- Optionally zero-fills a RAM region after reset.
- Sits between the pipeline output stage and the HPS-visible OCM. Successor to the fixed 10-channel / 15-pixel writer, adding a ready handshake, a done pulse, re-arming, and parametrised geometry.

Parameters:
- NUM_CH, 10, channels per input vector
- DATA_W, 8, bits per channel word and per RAM word
- NUM_PIX, 16, vectors captured per frame
- ADDR_W, 17, RAM word-address width
- BASE_ADDR, 0, first RAM address of the frame image
- CLEAR_WORDS, 4001, words zeroed in CLEAR, at addresses 0..CLEAR_WORDS-1
- AUTO_REARM, 0, 1 = DONE returns straight to CAPTURE; 0 = wait for start

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  one-cycle pulse; arms the next frame from HALT
- in_valid  in  1  in_data valid
- in_data  in  NUM_CH*DATA_W  channel 0 in the MSBs
- in_ready  out  1  capture possible this cycle
- ocm_writedata  out  DATA_W  RAM write data
- ocm_addr  out  ADDR_W  RAM word address
- ocm_chipselect  out  1  RAM chip select
- ocm_clken  out  1  RAM clock enable
- ocm_write  out  1  RAM write strobe, one word per high cycle
- busy  out  1  high in CLEAR, CAPTURE and DRAIN
- done  out  1  one-cycle pulse after the last drain write
- wr_count  out  16  data words written since reset (excludes clear writes)

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: every output is 0 and all counters are 0. State after reset is CLEAR, or CAPTURE when the clear feature is compiled out.
- All outputs are registered. A write beat appears on the RAM port the cycle after the FSM decides it.
- CLEAR:
  - Drives writedata=0 and chipselect=clken=write=1.
  - addr steps 0..CLEAR_WORDS-1, one word per cycle: exactly CLEAR_WORDS write cycles.
  - Then go to CAPTURE. in_ready=0 throughout.
- CAPTURE:
  - in_ready=1 while pix_cnt<NUM_PIX.
  - On a beat (in_valid&&in_ready), store in_data into buf[pix_cnt] and increment pix_cnt.
  - Once the NUM_PIX-th vector is accepted, in_ready falls the next cycle and the state goes to DRAIN. No extra vector is ever captured.
  - in_valid while in_ready=0 is ignored and the data is dropped; the producer must hold it.
- DRAIN:
  - Loop order: channel c outer, pixel p inner.
  - Each cycle write buf[p][c] to BASE_ADDR + c*NUM_PIX + p.
  - NUM_CH*NUM_PIX consecutive write cycles with no bubbles, including at channel boundaries.
  - wr_count increments per write and saturates at 16'hFFFF.
- DONE:
  - done=1 for exactly one cycle; write=0.
  - Next state is CAPTURE if AUTO_REARM=1, else HALT. pix_cnt clears.
- HALT:
  - in_ready=0. start moves to CAPTURE next cycle.
  - start in any other state is ignored.
- Outside CLEAR and DRAIN: write=0; clken and chipselect stay 1; addr and writedata hold their last value.
- Address arithmetic is done in ADDR_W bits. The elaboration check BASE_ADDR + NUM_CH*NUM_PIX <= 2^ADDR_W is mandatory, so addresses never wrap.
- Counter widths are $clog2 of the range, at least 1 bit.
- Reset asserted mid-DRAIN or mid-CLEAR: write drops asynchronously, the buffer contents are discarded, and the block restarts from CLEAR.

Optional Feature:
- Macro: OCM_WRITER_CLEAR_EN.
- Defined: the CLEAR state exists and runs after every reset.
- Undefined: CLEAR logic and its counter are removed. Reset enters CAPTURE directly, in_ready=1 on the first cycle after reset, and no zero writes are issued.

Decomposition:
- Package ocm_writer_pkg holds:
  - the state enum (CLEAR, CAPTURE, DRAIN, DONE, HALT)
  - the default geometry constants
  - the function ocm_addr_of(c, p) = BASE_ADDR + c*NUM_PIX + p
- Sub-module ocm_vec_buffer: NUM_PIX x NUM_CH register file. Write port is one full vector; read port is one word selected by (p, c).

Test Plan:
- Reset with CLEAR_EN, CLEAR_WORDS=4001 -> exactly 4001 write beats at addr 0..4000 with data 0, then in_ready=1, wr_count=0.
- 16 vectors, channel c of pixel p = p*16+c -> 160 writes with no gaps; addr 0x23 carries data 0x32 (c=2, p=3); done pulses once; wr_count=160.
- in_valid held high with 20 vectors queued, AUTO_REARM=0 -> only the first 16 are accepted; in_ready=0 from the cycle after the 16th beat until start.
- AUTO_REARM=1, three back-to-back frames with BASE_ADDR=0x100 -> done pulses three times and wr_count=480; each frame rewrites 0x100..0x19F.
- Reset pulsed on the 50th drain write -> write falls immediately; after release CLEAR restarts at addr 0; the partial frame is not resumed.
- Build without OCM_WRITER_CLEAR_EN -> first cycle after reset in_ready=1, and no writes occur before the first drain.

Source files
------------

// File: rtl/ocm_writer_pkg.sv
// ocm_writer_pkg: FSM states, default geometry and the frame address helper for ocm_channel_writer
package ocm_writer_pkg;
  localparam int DEF_NUM_CH      = 10;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_NUM_PIX     = 16;
  localparam int DEF_ADDR_W      = 17;
  localparam int DEF_BASE_ADDR   = 0;
  localparam int DEF_CLEAR_WORDS = 4001;
  typedef logic [2:0] state_t;
  localparam logic [2:0] S_CLEAR   = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;
  function automatic int ocm_addr_of(input int c, input int p, input int base = DEF_BASE_ADDR,
                                     input int npix = DEF_NUM_PIX);
    return base + c * npix + p;
  endfunction
endpackage

// File: rtl/ocm_vec_buffer.sv
// ocm_vec_buffer: NUM_PIX x NUM_CH word store, one whole vector written per beat, one word read by (pixel, channel)
module ocm_vec_buffer #(
  parameter int NUM_CH  = 10,
  parameter int DATA_W  = 8,
  parameter int NUM_PIX = 16,
  parameter int PW      = 4,
  parameter int CW      = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [PW-1:0]            wp_i,
  input  logic [NUM_CH*DATA_W-1:0] wdata_i,
  input  logic [PW-1:0]            rp_i,
  input  logic [CW-1:0]            rc_i,
  output logic [DATA_W-1:0]        rdata_o
);
  logic [DATA_W-1:0] mem_q [NUM_PIX][NUM_CH];
  // Split the incoming vector into channel words, channel 0 taken from the MSBs; every slot is rewritten each frame so no reset is needed
  always_ff @(posedge clk)
    if (we_i)
      for (int c = 0; c < NUM_CH; c++) mem_q[wp_i][c] <= wdata_i[(NUM_CH-1-c)*DATA_W +: DATA_W];
  assign rdata_o = mem_q[rp_i][rc_i];
endmodule

// File: rtl/ocm_channel_writer.sv
// ocm_channel_writer: captures NUM_PIX channel vectors and writes them channel-major into OCM; define OCM_WRITER_CLEAR_EN for a post-reset zero-fill
module ocm_channel_writer
  import ocm_writer_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_PIX     = DEF_NUM_PIX,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int CLEAR_WORDS = DEF_CLEAR_WORDS,
  parameter int AUTO_REARM  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        ocm_writedata,
  output logic [ADDR_W-1:0]        ocm_addr,
  output logic                     ocm_chipselect,
  output logic                     ocm_clken,
  output logic                     ocm_write,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              wr_count
);
  localparam int PW = NUM_PIX > 1 ? $clog2(NUM_PIX) : 1;
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
`ifdef OCM_WRITER_CLEAR_EN
  localparam int KW = CLEAR_WORDS > 1 ? $clog2(CLEAR_WORDS) : 1;
  localparam logic [2:0] S_RST = S_CLEAR;
  logic [KW-1:0] clr_q, clr_d;
  logic clr_last;
  assign clr_last = clr_q == KW'(CLEAR_WORDS - 1);
`else
  localparam logic [2:0] S_RST = S_CAPTURE;
`endif
  if (longint'(BASE_ADDR) + longint'(NUM_CH) * longint'(NUM_PIX) > (longint'(1) << ADDR_W)) begin : g_addr_chk
    $error("ocm_channel_writer: frame image does not fit in ADDR_W address bits");
  end
  if (CLEAR_WORDS < 1 || longint'(CLEAR_WORDS) > (longint'(1) << ADDR_W)) begin : g_clr_chk
    $error("ocm_channel_writer: CLEAR_WORDS out of range");
  end
  state_t state_q, state_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic write_q, write_d, done_q, done_d, in_ready_q, busy_q, en_q;
  logic beat, pix_last, ch_last;
  assign beat     = in_valid && in_ready_q;
  assign pix_last = pix_q == PW'(NUM_PIX - 1);
  assign ch_last  = ch_q == CW'(NUM_CH - 1);
  ocm_vec_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .NUM_PIX(NUM_PIX), .PW(PW), .CW(CW)) u_buf (
    .clk     (clk),
    .we_i    (beat),
    .wp_i    (pix_q),
    .wdata_i (in_data),
    .rp_i    (pix_q),
    .rc_i    (ch_q),
    .rdata_o (rd)
  );
  // Next-state and next-output decision; the pixel counter doubles as the inner drain index
  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    ch_d     = ch_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = 1'b0;
    done_d   = 1'b0;
    wr_cnt_d = wr_cnt_q;
`ifdef OCM_WRITER_CLEAR_EN
    clr_d    = clr_q;
`endif
    case (state_q)
`ifdef OCM_WRITER_CLEAR_EN
      S_CLEAR: begin
        write_d = 1'b1;
        addr_d  = ADDR_W'(clr_q);
        wdata_d = '0;
        clr_d   = clr_last ? '0 : clr_q + 1'b1;
        state_d = clr_last ? S_CAPTURE : S_CLEAR;
      end
`endif
      S_CAPTURE: if (beat) begin
        pix_d   = pix_last ? '0 : pix_q + 1'b1;
        state_d = pix_last ? S_DRAIN : S_CAPTURE;
      end
      S_DRAIN: begin
        write_d  = 1'b1;
        addr_d   = ADDR_W'(ocm_addr_of(int'(ch_q), int'(pix_q), BASE_ADDR, NUM_PIX));
        wdata_d  = rd;
        wr_cnt_d = &wr_cnt_q ? wr_cnt_q : wr_cnt_q + 16'd1;
        pix_d    = pix_last ? '0 : pix_q + 1'b1;
        ch_d     = pix_last ? (ch_last ? '0 : ch_q + 1'b1) : ch_q;
        state_d  = pix_last && ch_last ? S_DONE : S_DRAIN;
      end
      S_DONE: begin
        done_d  = 1'b1;
        pix_d   = '0;
        state_d = AUTO_REARM != 0 ? S_CAPTURE : S_HALT;
      end
      S_HALT: state_d = start ? S_CAPTURE : S_HALT;
      default: state_d = S_RST;
    endcase
  end
  // Register state and every output so the RAM port sees each beat one cycle after the decision
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= S_RST;
      pix_q      <= '0;
      ch_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_cnt_q   <= '0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
`ifdef OCM_WRITER_CLEAR_EN
      clr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      ch_q       <= ch_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_cnt_q   <= wr_cnt_d;
      write_q    <= write_d;
      done_q     <= done_d;
      in_ready_q <= state_d == S_CAPTURE;
      busy_q     <= state_d == S_CLEAR || state_d == S_CAPTURE || state_d == S_DRAIN;
      en_q       <= 1'b1;
`ifdef OCM_WRITER_CLEAR_EN
      clr_q      <= clr_d;
`endif
    end
  assign in_ready       = in_ready_q;
  assign ocm_writedata  = wdata_q;
  assign ocm_addr       = addr_q;
  assign ocm_chipselect = en_q;
  assign ocm_clken      = en_q;
  assign ocm_write      = write_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign wr_count       = wr_cnt_q;
endmodule
